// File: rtl/vga_timing_pkg.sv
// Shared types, default 640x480@60 timing and helpers for the VGA raster generator.
package vga_timing_pkg;

  localparam int VGA_CW = 11;
  localparam int VGA_DW = 10;

  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FP     = 16;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BP     = 48;
  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FP     = 10;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BP     = 33;

  typedef struct packed {
    logic [VGA_DW-1:0] r;
    logic [VGA_DW-1:0] g;
    logic [VGA_DW-1:0] b;
  } vga_rgb_t;

  // Syncs are stored at their output level, so an entry can be driven straight to the pins.
  typedef struct packed {
    logic              hs;
    logic              vs;
    logic              active;
    logic [VGA_CW-1:0] x;
  } vga_sync_t;

  function automatic int total(input int act, input int fp, input int sync, input int bp);
    return act + fp + sync + bp;
  endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Enable-gated shift register of raster attributes; aligns syncs and blanking with
// pixel data returned by the source PIPE_LAT ticks after the request.
module vga_delay_line
  import vga_timing_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic      i_clk,
  input  logic      i_rst,
  input  logic      i_en,
  input  vga_sync_t i_rst_val,
  input  vga_sync_t i_d,
  output vga_sync_t o_q
);

  vga_sync_t stage_q [DEPTH];
  vga_sync_t stage_d [DEPTH];

  always_comb begin
    // NOTE: every always_comb output gets a default first, otherwise a missed branch infers a latch.
    stage_d = stage_q;
    if (i_en) begin
      stage_d[0] = i_d;
      for (int i = 1; i < DEPTH; i++) begin
        stage_d[i] = stage_q[i-1];
      end
    end
  end

  // NOTE: this array is reset on purpose; stale stages would otherwise leak a visible pixel after reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_q[i] <= i_rst_val;
      end
    end else begin
      stage_q <= stage_d;
    end
  end

  assign o_q = stage_q[DEPTH-1];

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster generator: pixel requests, coordinates, linear address, syncs and
// registered colour. Optional colour-bar source enabled by VGA_TIMING_TEST_PATTERN_EN.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE = VGA_H_ACTIVE,
  parameter int H_FP     = VGA_H_FP,
  parameter int H_SYNC   = VGA_H_SYNC,
  parameter int H_BP     = VGA_H_BP,
  parameter int V_ACTIVE = VGA_V_ACTIVE,
  parameter int V_FP     = VGA_V_FP,
  parameter int V_SYNC   = VGA_V_SYNC,
  parameter int V_BP     = VGA_V_BP,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int PIPE_LAT = 1,
  parameter int CW       = VGA_CW,
  parameter int AW       = 22,
  parameter int DW       = VGA_DW
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_en,
  input  logic [DW-1:0] i_red,
  input  logic [DW-1:0] i_green,
  input  logic [DW-1:0] i_blue,
`ifdef VGA_TIMING_TEST_PATTERN_EN
  input  logic          i_test_mode,
`endif
  output logic          o_req,
  output logic [CW-1:0] o_x,
  output logic [CW-1:0] o_y,
  output logic [AW-1:0] o_addr,
  output logic [DW-1:0] o_vga_r,
  output logic [DW-1:0] o_vga_g,
  output logic [DW-1:0] o_vga_b,
  output logic          o_hs,
  output logic          o_vs,
  output logic          o_blank_n,
  output logic          o_sync_n,
  output logic          o_frame_start
);

  localparam int H_TOTAL  = total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL  = total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam int HS_START = H_ACTIVE + H_FP;
  localparam int VS_START = V_ACTIVE + V_FP;

  logic [CW-1:0] h_q, h_d, v_q, v_d, x_q, x_d, y_q, y_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          req_q, req_d, frame_start_q, frame_start_d;
  logic          hs_q, hs_d, vs_q, vs_d, blank_n_q, blank_n_d;
  vga_rgb_t      rgb_q, rgb_d, src_rgb;
  vga_sync_t     dly_in, dly_rst, dly_q;
  logic          at_origin, cur_active;

  always_comb begin
    at_origin  = (h_q == '0) && (v_q == '0);
    cur_active = (h_q < CW'(H_ACTIVE)) && (v_q < CW'(V_ACTIVE));
    dly_in.hs  = (h_q >= CW'(HS_START) && h_q < CW'(HS_START + H_SYNC)) ? HS_POL : ~HS_POL;
    dly_in.vs  = (v_q >= CW'(VS_START) && v_q < CW'(VS_START + V_SYNC)) ? VS_POL : ~VS_POL;
    dly_in.active = cur_active;
    dly_in.x      = VGA_CW'(h_q);
    dly_rst       = '{hs: ~HS_POL, vs: ~VS_POL, active: 1'b0, x: '0};
  end

  vga_delay_line #(.DEPTH(PIPE_LAT)) u_delay (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_en      (i_en),
    .i_rst_val (dly_rst),
    .i_d       (dly_in),
    .o_q       (dly_q)
  );

`ifdef VGA_TIMING_TEST_PATTERN_EN
  localparam int BAR_W = (H_ACTIVE >= 8) ? H_ACTIVE / 8 : 1;
  logic [2:0] bar_idx;

  always_comb begin
    bar_idx = 3'(dly_q.x / VGA_CW'(BAR_W));
    if (i_test_mode) begin
      src_rgb = '{r: {VGA_DW{bar_idx[2]}}, g: {VGA_DW{bar_idx[1]}}, b: {VGA_DW{bar_idx[0]}}};
    end else begin
      src_rgb = '{r: VGA_DW'(i_red), g: VGA_DW'(i_green), b: VGA_DW'(i_blue)};
    end
  end
`else
  logic unused_dly_x;
  assign unused_dly_x = ^dly_q.x;
  assign src_rgb      = '{r: VGA_DW'(i_red), g: VGA_DW'(i_green), b: VGA_DW'(i_blue)};
`endif

  always_comb begin
    h_d           = h_q;
    v_d           = v_q;
    x_d           = x_q;
    y_d           = y_q;
    req_d         = req_q;
    addr_d        = addr_q;
    hs_d          = hs_q;
    vs_d          = vs_q;
    blank_n_d     = blank_n_q;
    rgb_d         = rgb_q;
    frame_start_d = 1'b0;  // a one-clock pulse even when the next clock is not a tick
    if (i_en) begin
      x_d           = h_q;
      y_d           = v_q;
      req_d         = cur_active;
      frame_start_d = at_origin;
      // Incremental address: counts presented visible pixels, restarts at the frame origin.
      if (at_origin)  addr_d = '0;
      else if (req_q) addr_d = addr_q + AW'(1);
      if (h_q == CW'(H_TOTAL - 1)) begin
        h_d = '0;
        v_d = (v_q == CW'(V_TOTAL - 1)) ? '0 : v_q + CW'(1);
      end else begin
        h_d = h_q + CW'(1);
      end
      hs_d      = dly_q.hs;
      vs_d      = dly_q.vs;
      blank_n_d = dly_q.active;
      rgb_d     = dly_q.active ? src_rgb : '0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      h_q           <= '0;
      v_q           <= '0;
      x_q           <= '0;
      y_q           <= '0;
      req_q         <= 1'b0;
      addr_q        <= '0;
      hs_q          <= ~HS_POL;
      vs_q          <= ~VS_POL;
      blank_n_q     <= 1'b0;
      rgb_q         <= '0;
      frame_start_q <= 1'b0;
    end else begin
      h_q           <= h_d;
      v_q           <= v_d;
      x_q           <= x_d;
      y_q           <= y_d;
      req_q         <= req_d;
      addr_q        <= addr_d;
      hs_q          <= hs_d;
      vs_q          <= vs_d;
      blank_n_q     <= blank_n_d;
      rgb_q         <= rgb_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign o_req         = req_q;
  assign o_x           = x_q;
  assign o_y           = y_q;
  assign o_addr        = addr_q;
  assign o_vga_r       = DW'(rgb_q.r);
  assign o_vga_g       = DW'(rgb_q.g);
  assign o_vga_b       = DW'(rgb_q.b);
  assign o_hs          = hs_q;
  assign o_vs          = vs_q;
  assign o_blank_n     = blank_n_q;
  assign o_sync_n      = 1'b0;
  assign o_frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a small 16x8-total raster (PIPE_LAT=3, active-high hsync)
// checked against hand-computed vectors, plus a default 640x480 instance for line timing.
module tb_vga_timing_gen;

  localparam int CW = 11;
  localparam int AW = 22;
  localparam int DW = 10;
  localparam logic [DW-1:0] DEF_PIX = 10'h2AA;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, en, rst_def, force_ones;
  logic [DW-1:0] s1, s2, src_r, src_g, src_b;

  logic          req, hs, vs, blank_n, sync_n, fs;
  logic [CW-1:0] x, y;
  logic [AW-1:0] addr;
  logic [DW-1:0] r, g, b;

  logic          req_d, hs_d, vs_d, blank_n_d, sync_n_d, fs_d;
  logic [CW-1:0] x_d, y_d;
  logic [AW-1:0] addr_d;
  logic [DW-1:0] r_d, g_d, b_d;

`ifdef VGA_TIMING_TEST_PATTERN_EN
  logic test_mode;
`endif

  // Source model: returns o_addr[9:0] on R (inverted on G) two ticks later, so the
  // DUT samples it on its third tick after the request.
  always @(posedge clk) begin
    if (en) begin
      s1 <= addr[9:0];
      s2 <= s1;
    end
  end
  assign src_r = force_ones ? '1 : s2;
  assign src_g = force_ones ? '1 : ~s2;
  assign src_b = force_ones ? '1 : s2;

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HS_POL(1'b1), .VS_POL(1'b0), .PIPE_LAT(3),
    .CW(CW), .AW(AW), .DW(DW)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_en(en),
    .i_red(src_r), .i_green(src_g), .i_blue(src_b),
`ifdef VGA_TIMING_TEST_PATTERN_EN
    .i_test_mode(test_mode),
`endif
    .o_req(req), .o_x(x), .o_y(y), .o_addr(addr),
    .o_vga_r(r), .o_vga_g(g), .o_vga_b(b),
    .o_hs(hs), .o_vs(vs), .o_blank_n(blank_n), .o_sync_n(sync_n),
    .o_frame_start(fs)
  );

  vga_timing_gen dut_def (
    .i_clk(clk), .i_rst(rst_def), .i_en(1'b1),
    .i_red(DEF_PIX), .i_green(DEF_PIX), .i_blue(DEF_PIX),
`ifdef VGA_TIMING_TEST_PATTERN_EN
    .i_test_mode(1'b0),
`endif
    .o_req(req_d), .o_x(x_d), .o_y(y_d), .o_addr(addr_d),
    .o_vga_r(r_d), .o_vga_g(g_d), .o_vga_b(b_d),
    .o_hs(hs_d), .o_vs(vs_d), .o_blank_n(blank_n_d), .o_sync_n(sync_n_d),
    .o_frame_start(fs_d)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic clk_step();
    @(posedge clk);
    #1;
  endtask

  // tick: enabled clocks since reset; outputs after tick n show position n-1, colour/syncs position n-4.
  typedef struct {
    int tick; int x; int y; int req; int addr; int fs; int hs; int vs; int blank; int r;
  } vec_t;
  localparam int NV = 20;
  vec_t vecs [NV];

  int tick_n, nreq, nfs;
  int rise1, fall1, rise2, fall2;
  logic prev;

  initial begin
    rst = 1'b1; en = 1'b1; rst_def = 1'b1; force_ones = 1'b0;
`ifdef VGA_TIMING_TEST_PATTERN_EN
    test_mode = 1'b0;
`endif
    //          tick  x  y req addr fs hs vs bl  r
    vecs[0]  = '{  0, 0, 0, 0,  0, 0, 0, 1, 0,  0};
    vecs[1]  = '{  1, 0, 0, 1,  0, 1, 0, 1, 0,  0};
    vecs[2]  = '{  2, 1, 0, 1,  1, 0, 0, 1, 0,  0};
    vecs[3]  = '{  4, 3, 0, 1,  3, 0, 0, 1, 1,  0};
    vecs[4]  = '{  5, 4, 0, 1,  4, 0, 0, 1, 1,  1};
    vecs[5]  = '{  8, 7, 0, 1,  7, 0, 0, 1, 1,  4};
    vecs[6]  = '{  9, 8, 0, 0,  0, 0, 0, 1, 1,  5};
    vecs[7]  = '{ 12,11, 0, 0,  0, 0, 0, 1, 0,  0};
    vecs[8]  = '{ 14,13, 0, 0,  0, 0, 1, 1, 0,  0};
    vecs[9]  = '{ 16,15, 0, 0,  0, 0, 1, 1, 0,  0};
    vecs[10] = '{ 17, 0, 1, 1,  8, 0, 0, 1, 0,  0};
    vecs[11] = '{ 56, 7, 3, 1, 31, 0, 0, 1, 1, 28};
    vecs[12] = '{ 60,11, 3, 0,  0, 0, 0, 1, 0,  0};
    vecs[13] = '{ 81, 0, 5, 0,  0, 0, 0, 1, 0,  0};
    vecs[14] = '{ 84, 3, 5, 0,  0, 0, 0, 0, 0,  0};
    vecs[15] = '{ 94,13, 5, 0,  0, 0, 1, 0, 0,  0};
    vecs[16] = '{104, 7, 6, 1,  0, 0, 0, 0, 0,  0};
    vecs[17] = '{116, 3, 7, 0,  0, 0, 0, 1, 0,  0};
    vecs[18] = '{129, 0, 0, 1,  0, 1, 0, 1, 0,  0};
    vecs[19] = '{133, 4, 0, 1,  4, 0, 0, 1, 1,  1};
    vecs[16].req = 0;  // (7,6) lies in vertical sync

    clk_step(); clk_step();
    rst = 1'b0;
    tick_n = 0;
    check("sync_n", 32'(sync_n), 0);

    for (int i = 0; i < NV; i++) begin
      while (tick_n < vecs[i].tick) begin
        clk_step();
        tick_n++;
      end
      check($sformatf("t%0d_x", vecs[i].tick), 32'(x), vecs[i].x);
      check($sformatf("t%0d_y", vecs[i].tick), 32'(y), vecs[i].y);
      check($sformatf("t%0d_req", vecs[i].tick), 32'(req), vecs[i].req);
      if (vecs[i].req != 0) check($sformatf("t%0d_addr", vecs[i].tick), 32'(addr), vecs[i].addr);
      check($sformatf("t%0d_fs", vecs[i].tick), 32'(fs), vecs[i].fs);
      check($sformatf("t%0d_hs", vecs[i].tick), 32'(hs), vecs[i].hs);
      check($sformatf("t%0d_vs", vecs[i].tick), 32'(vs), vecs[i].vs);
      check($sformatf("t%0d_blank_n", vecs[i].tick), 32'(blank_n), vecs[i].blank);
      check($sformatf("t%0d_r", vecs[i].tick), 32'(r), vecs[i].r);
      check($sformatf("t%0d_g", vecs[i].tick), 32'(g), (vecs[i].blank != 0) ? (vecs[i].r ^ 'h3FF) : 0);
      check($sformatf("t%0d_b", vecs[i].tick), 32'(b), vecs[i].r);
    end

    // i_en toggling: outputs hold on idle clocks, periods double, frame_start stays one clock.
    rst = 1'b1; clk_step(); rst = 1'b0; en = 1'b1;
    clk_step(); check("tog_x0", 32'(x), 0); check("tog_fs_on", 32'(fs), 1);
    en = 1'b0;
    clk_step(); check("tog_hold_x0", 32'(x), 0); check("tog_hold_req", 32'(req), 1);
    check("tog_fs_width", 32'(fs), 0);
    en = 1'b1;
    clk_step(); check("tog_x1", 32'(x), 1); check("tog_addr1", 32'(addr), 1);
    en = 1'b0;
    clk_step(); check("tog_hold_x1", 32'(x), 1); check("tog_hold_addr1", 32'(addr), 1);
    rise1 = -1; fall1 = -1; rise2 = -1; prev = hs;
    for (int c = 1; c <= 400; c++) begin
      en = ~en;
      clk_step();
      if (hs && !prev) begin
        if (rise1 < 0) rise1 = c;
        else if (rise2 < 0) rise2 = c;
      end
      if (!hs && prev && rise1 >= 0 && fall1 < 0) fall1 = c;
      prev = hs;
    end
    check("tog_hs_active_clks", 32'(fall1 - rise1), 6);
    check("tog_hs_period_clks", 32'(rise2 - rise1), 32);

    // Reset mid-frame at (5,2).
    en = 1'b1; rst = 1'b1; clk_step(); rst = 1'b0;
    repeat (38) clk_step();
    check("pre_rst_x", 32'(x), 5); check("pre_rst_y", 32'(y), 2); check("pre_rst_addr", 32'(addr), 21);
    rst = 1'b1; clk_step();
    check("rst_x", 32'(x), 0); check("rst_y", 32'(y), 0); check("rst_req", 32'(req), 0);
    check("rst_addr", 32'(addr), 0); check("rst_fs", 32'(fs), 0); check("rst_hs", 32'(hs), 0);
    check("rst_vs", 32'(vs), 1); check("rst_blank_n", 32'(blank_n), 0); check("rst_r", 32'(r), 0);
    rst = 1'b0; clk_step();
    check("post_rst_x", 32'(x), 0); check("post_rst_y", 32'(y), 0); check("post_rst_req", 32'(req), 1);
    check("post_rst_fs", 32'(fs), 1); check("post_rst_addr", 32'(addr), 0);
    clk_step(); clk_step();
    check("post_rst_blank_t3", 32'(blank_n), 0);
    clk_step();
    check("post_rst_blank_t4", 32'(blank_n), 1);

    // One frame's worth of ticks (positions 4..131): 32 requests, one frame_start clock.
    nreq = 0; nfs = 0;
    repeat (128) begin
      clk_step();
      nreq += int'(req);
      nfs  += int'(fs);
    end
    check("frame_req_count", 32'(nreq), 32);
    check("frame_fs_count", 32'(nfs), 1);

`ifdef VGA_TIMING_TEST_PATTERN_EN
    test_mode = 1'b1; force_ones = 1'b1;
    rst = 1'b1; clk_step(); rst = 1'b0;
    for (int n = 1; n <= 12; n++) begin
      clk_step();
      if (n == 4)  check("tp_bar0", {r, g, b}, 30'h0);
      if (n == 9)  check("tp_bar5", {r, g, b}, {10'h3FF, 10'h000, 10'h3FF});
      if (n == 11) check("tp_bar7", {r, g, b}, {3{10'h3FF}});
      if (n == 12) check("tp_blank", {r, g, b}, 30'h0);
    end
    test_mode = 1'b0; force_ones = 1'b0;
`endif

    // Default 640x480 instance, PIPE_LAT=1: syncs/colour after tick n show position n-2.
    rst_def = 1'b0;
    fall1 = -1; rise1 = -1; fall2 = -1; prev = hs_d;
    for (int n = 1; n <= 1500; n++) begin
      clk_step();
      if (n == 1) begin
        check("def_fs", 32'(fs_d), 1); check("def_req00", 32'(req_d), 1);
        check("def_addr00", 32'(addr_d), 0);
      end
      if (n == 640) begin
        check("def_x639", 32'(x_d), 639); check("def_y0", 32'(y_d), 0);
        check("def_addr639", 32'(addr_d), 639);
      end
      if (n == 641) begin
        check("def_blank_last", 32'(blank_n_d), 1);
        check("def_rgb_last", {r_d, g_d, b_d}, {3{DEF_PIX}});
      end
      if (n == 642) begin
        check("def_blank_fp", 32'(blank_n_d), 0);
        check("def_rgb_fp", {r_d, g_d, b_d}, 30'h0);
      end
      if (n == 801) begin
        check("def_x0_line1", 32'(x_d), 0); check("def_y1", 32'(y_d), 1);
        check("def_addr640", 32'(addr_d), 640);
      end
      if (n == 1000) check("def_vs_idle", 32'(vs_d), 1);
      if (!hs_d && prev) begin
        if (fall1 < 0) fall1 = n;
        else if (fall2 < 0) fall2 = n;
      end
      if (hs_d && !prev && fall1 >= 0 && rise1 < 0) rise1 = n;
      prev = hs_d;
    end
    check("def_hs_first_fall", 32'(fall1), 658);
    check("def_hs_low_clks", 32'(rise1 - fall1), 96);
    check("def_hs_period", 32'(fall2 - fall1), 800);
    check("def_sync_n", 32'(sync_n_d), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
